// File: rtl/cam_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | cam_pkg : shared types and constants for the CAM and its controller  |
// | rev 1.0                                                              |
// +----------------------------------------------------------------------+
package cam_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    LOOKUP   = 3'd1,
    MISS_REQ = 3'd2,
    FILL     = 3'd3,
    RESP     = 3'd4
  } cam_state_e;

  // Default width of the saturating statistics counters.
  localparam int CAM_SAT_CNT_W = 16;

endpackage
`default_nettype wire

// File: rtl/cam_victim_ptr.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | cam_victim_ptr : round-robin replacement slot pointer                |
// | rev 1.0                                                              |
// +----------------------------------------------------------------------+
module cam_victim_ptr #(
  parameter int WORDS = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     advance_i,
  output logic [$clog2(WORDS)-1:0] ptr_o
);

  localparam int PTR_W = $clog2(WORDS);

  logic [PTR_W-1:0] ptr_q, ptr_d;

  always_comb begin
    ptr_d = ptr_q;
    if (advance_i) begin
      ptr_d = (ptr_q == PTR_W'(WORDS - 1)) ? '0 : ptr_q + PTR_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  assign ptr_o = ptr_q;

endmodule
`default_nettype wire

// File: rtl/cam_miss_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | cam_miss_ctrl : CAM lookup with backing-memory fill on miss          |
// | rev 1.0                                                              |
// +----------------------------------------------------------------------+
module cam_miss_ctrl
  import cam_pkg::*;
#(
  parameter int WORDS  = 8,
  parameter int BITS   = 8,
  parameter int TAG_SZ = 8,
  parameter int CNT_W  = CAM_SAT_CNT_W
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     req_valid,
  input  logic [TAG_SZ-1:0]        req_tag,
  output logic                     req_ready,
  output logic                     rsp_valid,
  output logic [BITS-1:0]          rsp_data,
  output logic                     rsp_hit,
  output logic                     cam_read,
  output logic [TAG_SZ-1:0]        cam_tag,
  input  logic                     cam_found,
  input  logic [BITS-1:0]          cam_data,
  output logic                     cam_write_,
  output logic [$clog2(WORDS)-1:0] cam_w_addr,
  output logic [BITS-1:0]          cam_wdata,
  output logic                     mem_req,
  output logic [TAG_SZ-1:0]        mem_addr,
  input  logic                     mem_ack,
  input  logic [BITS-1:0]          mem_rdata,
  output logic [CNT_W-1:0]         hit_cnt,
  output logic [CNT_W-1:0]         miss_cnt
);

  localparam int AW = $clog2(WORDS);

  cam_state_e        state_q, state_d;
  logic [TAG_SZ-1:0] tag_q, tag_d;
  logic [BITS-1:0]   data_q, data_d;
  logic              hit_q, hit_d;
  logic [CNT_W-1:0]  hit_cnt_q, hit_cnt_d;
  logic [CNT_W-1:0]  miss_cnt_q, miss_cnt_d;
  logic              hit_inc, miss_inc;
  logic              advance;
  logic [AW-1:0]     victim_ptr;

  cam_victim_ptr #(
    .WORDS (WORDS)
  ) u_victim_ptr (
    .clk       (clk),
    .rst       (rst),
    .advance_i (advance),
    .ptr_o     (victim_ptr)
  );

  always_comb begin
    state_d    = state_q;
    tag_d      = tag_q;
    data_d     = data_q;
    hit_d      = hit_q;
    hit_inc    = 1'b0;
    miss_inc   = 1'b0;
    advance    = 1'b0;
    req_ready  = 1'b0;
    rsp_valid  = 1'b0;
    cam_read   = 1'b0;
    cam_write_ = 1'b1;
    mem_req    = 1'b0;
    case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          tag_d   = req_tag;
          state_d = LOOKUP;
        end
      end
      LOOKUP: begin
        cam_read = 1'b1;
        if (cam_found) begin
          data_d  = cam_data;
          hit_d   = 1'b1;
          hit_inc = 1'b1;
          state_d = RESP;
        end else begin
          hit_d    = 1'b0;
          miss_inc = 1'b1;
          state_d  = MISS_REQ;
        end
      end
      MISS_REQ: begin
        mem_req = 1'b1;
        if (mem_ack) begin
          data_d  = mem_rdata;
          state_d = FILL;
        end
      end
      FILL: begin
        // The CAM writes on the same edge that reset would abort us on.
        cam_write_ = rst;
        advance    = 1'b1;
        state_d    = RESP;
      end
      RESP: begin
        rsp_valid = 1'b1;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    hit_cnt_d  = hit_cnt_q;
    miss_cnt_d = miss_cnt_q;
    if (hit_inc && (hit_cnt_q != '1)) begin
      hit_cnt_d = hit_cnt_q + CNT_W'(1);
    end
    if (miss_inc && (miss_cnt_q != '1)) begin
      miss_cnt_d = miss_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      tag_q      <= '0;
      data_q     <= '0;
      hit_q      <= 1'b0;
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      tag_q      <= tag_d;
      data_q     <= data_d;
      hit_q      <= hit_d;
      hit_cnt_q  <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
    end
  end

  assign cam_tag    = tag_q;
  assign mem_addr   = tag_q;
  assign cam_w_addr = victim_ptr;
  assign cam_wdata  = data_q;
  assign rsp_data   = data_q;
  assign rsp_hit    = hit_q;
  assign hit_cnt    = hit_cnt_q;
  assign miss_cnt   = miss_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_cam_miss_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_cam_miss_ctrl : directed self-checking bench for cam_miss_ctrl    |
// | rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_cam_miss_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       req_valid;
  logic [7:0] req_tag;
  logic       req_ready, rsp_valid, rsp_hit, cam_read, cam_write_, mem_req;
  logic [7:0] rsp_data, cam_tag, cam_wdata, mem_addr;
  logic [2:0] cam_w_addr;
  logic       cam_found;
  logic [7:0] cam_data;
  logic       mem_ack;
  logic [7:0] mem_rdata;
  logic [15:0] hit_cnt, miss_cnt;

  logic       s_req_ready, s_rsp_valid, s_rsp_hit, s_cam_read, s_cam_write_, s_mem_req;
  logic [7:0] s_rsp_data, s_cam_tag, s_cam_wdata, s_mem_addr;
  logic [2:0] s_cam_w_addr;
  logic [1:0] s_hit_cnt, s_miss_cnt;

  int vec  = 0;
  int errs = 0;

  always #5 clk = ~clk;

  cam_miss_ctrl u_dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_tag(req_tag),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_hit(rsp_hit),
    .cam_read(cam_read), .cam_tag(cam_tag), .cam_found(cam_found), .cam_data(cam_data),
    .cam_write_(cam_write_), .cam_w_addr(cam_w_addr), .cam_wdata(cam_wdata),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
  );

  // Narrow-counter twin fed the same stimulus, for counter saturation.
  cam_miss_ctrl #(.CNT_W(2)) u_sat (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_tag(req_tag),
    .req_ready(s_req_ready), .rsp_valid(s_rsp_valid), .rsp_data(s_rsp_data), .rsp_hit(s_rsp_hit),
    .cam_read(s_cam_read), .cam_tag(s_cam_tag), .cam_found(cam_found), .cam_data(cam_data),
    .cam_write_(s_cam_write_), .cam_w_addr(s_cam_w_addr), .cam_wdata(s_cam_wdata),
    .mem_req(s_mem_req), .mem_addr(s_mem_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .hit_cnt(s_hit_cnt), .miss_cnt(s_miss_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // CAM model
  logic [7:0] m_tag [8];
  logic [7:0] m_dat [8];
  logic       m_vld [8];

  always_comb begin
    cam_found = 1'b0;
    cam_data  = 8'h00;
    if (cam_read) begin
      for (int i = 0; i < 8; i++) begin
        if (m_vld[i] && (m_tag[i] == cam_tag)) begin
          cam_found = 1'b1;
          cam_data  = m_dat[i];
        end
      end
    end
  end

  always @(posedge clk) begin
    if (!cam_write_) begin
      m_tag[cam_w_addr] <= cam_tag;
      m_dat[cam_w_addr] <= cam_wdata;
      m_vld[cam_w_addr] <= 1'b1;
    end
  end

  // Memory model: ack ack_dly cycles after mem_req is first seen; data = addr ^ 0xB4
  int ack_dly;
  int ack_cnt;
  assign mem_rdata = mem_addr ^ 8'hB4;

  always @(posedge clk) begin
    if (mem_req && !mem_ack) begin
      if (ack_cnt == ack_dly) mem_ack <= 1'b1;
      else                    ack_cnt <= ack_cnt + 1;
    end else begin
      mem_ack <= 1'b0;
      ack_cnt <= 0;
    end
  end

  // Observation at the falling edge
  int         cyc = 0, acc_cyc = 0, rsp_cyc = 0, rsp_cnt = 0, wr_cnt = 0;
  logic [7:0] rsp_d, w_tag, w_data, cur_tag;
  logic       rsp_h;
  logic [2:0] w_addr;

  always @(negedge clk) begin
    cyc++;
    if (req_valid && req_ready) acc_cyc = cyc;
    if (rsp_valid) begin
      rsp_cnt++;
      rsp_cyc = cyc;
      rsp_d   = rsp_data;
      rsp_h   = rsp_hit;
    end
    if (!cam_write_) begin
      wr_cnt++;
      w_addr = cam_w_addr;
      w_tag  = cam_tag;
      w_data = cam_wdata;
    end
    if (mem_req && !rst) chk("mem_addr_stable", mem_addr, cur_tag);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_req(input logic [7:0] t, input int dly);
    int n0;
    ack_dly   = dly;
    cur_tag   = t;
    n0        = rsp_cnt;
    req_valid = 1'b1;
    req_tag   = t;
    step();
    req_valid = 1'b0;
    for (int i = 0; i < 60 && rsp_cnt == n0; i++) step();
    chk("rsp_timeout", 32'(rsp_cnt != n0), 32'd1);
  endtask

  int n0, w0, busy_ready;

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    rst       = 1'b1;
    req_valid = 1'b0;
    req_tag   = 8'h00;
    ack_dly   = 0;
    ack_cnt   = 0;
    mem_ack   = 1'b0;
    cur_tag   = 8'h00;
    for (int i = 0; i < 8; i++) begin
      m_vld[i] = 1'b0;
      m_tag[i] = 8'h00;
      m_dat[i] = 8'h00;
    end
    m_vld[2] = 1'b1;
    m_tag[2] = 8'h5A;
    m_dat[2] = 8'h3C;
    step();
    step();

    chk("rst_req_ready",  32'(req_ready),  32'd1);
    chk("rst_cam_write_", 32'(cam_write_), 32'd1);
    chk("rst_rsp_valid",  32'(rsp_valid),  32'd0);
    chk("rst_cam_read",   32'(cam_read),   32'd0);
    chk("rst_mem_req",    32'(mem_req),    32'd0);
    chk("rst_rsp_data",   32'(rsp_data),   32'd0);
    chk("rst_cam_w_addr", 32'(cam_w_addr), 32'd0);
    chk("rst_cam_tag",    32'(cam_tag),    32'd0);
    chk("rst_hit_cnt",    32'(hit_cnt),    32'd0);
    chk("rst_miss_cnt",   32'(miss_cnt),   32'd0);
    rst = 1'b0;
    step();

    // Hit on preloaded slot 2; latency counts acceptance, LOOKUP and RESP cycles
    do_req(8'h5A, 0);
    chk("hit_data", 32'(rsp_d), 32'h3C);
    chk("hit_flag", 32'(rsp_h), 32'd1);
    chk("hit_lat",  32'(rsp_cyc - acc_cyc + 1), 32'd3);
    chk("hit_cnt1", 32'(hit_cnt),  32'd1);
    chk("hit_miss0", 32'(miss_cnt), 32'd0);
    chk("hit_nowr", 32'(wr_cnt), 32'd0);

    // Miss: ack two cycles after mem_req rises, so MISS_REQ lasts three cycles
    w0 = wr_cnt;
    do_req(8'h11, 1);
    chk("miss_wr",    32'(wr_cnt), 32'(w0 + 1));
    chk("miss_waddr", 32'(w_addr), 32'd0);
    chk("miss_wtag",  32'(w_tag),  32'h11);
    chk("miss_wdata", 32'(w_data), 32'hA5);
    chk("miss_data",  32'(rsp_d),  32'hA5);
    chk("miss_flag",  32'(rsp_h),  32'd0);
    chk("miss_cnt1",  32'(miss_cnt), 32'd1);
    chk("miss_lat",   32'(rsp_cyc - acc_cyc + 1), 32'd7);

    // Backpressure: req_valid held through a miss on tag 0x77
    ack_dly    = 1;
    cur_tag    = 8'h77;
    n0         = rsp_cnt;
    busy_ready = 0;
    req_valid  = 1'b1;
    req_tag    = 8'h77;
    step();
    for (int i = 0; i < 60 && rsp_cnt == n0; i++) begin
      if (req_ready) busy_ready++;
      step();
    end
    chk("bp_timeout",   32'(rsp_cnt != n0), 32'd1);
    chk("bp_busy_rdy",  32'(busy_ready), 32'd0);
    chk("bp_waddr",     32'(w_addr), 32'd1);
    chk("bp_idle_rdy",  32'(req_ready), 32'd1);
    step();
    req_valid = 1'b0;
    chk("bp_accepted",  32'(req_ready), 32'd0);
    n0 = rsp_cnt;
    for (int i = 0; i < 60 && rsp_cnt == n0; i++) step();
    chk("bp_hit_flag",  32'(rsp_h), 32'd1);
    chk("bp_hit_data",  32'(rsp_d), 32'hC3);
    chk("bp_hit_cnt",   32'(hit_cnt),  32'd2);
    chk("bp_miss_cnt",  32'(miss_cnt), 32'd2);

    // Reset while waiting in MISS_REQ
    ack_dly   = 20;
    cur_tag   = 8'h99;
    req_valid = 1'b1;
    req_tag   = 8'h99;
    step();
    req_valid = 1'b0;
    step();
    chk("rm_in_miss", 32'(mem_req), 32'd1);
    n0  = rsp_cnt;
    w0  = wr_cnt;
    rst = 1'b1;
    step();
    chk("rm_idle_rdy", 32'(req_ready), 32'd1);
    chk("rm_mem_req",  32'(mem_req),   32'd0);
    rst = 1'b0;
    repeat (5) step();
    chk("rm_no_rsp",  32'(rsp_cnt),  32'(n0));
    chk("rm_no_wr",   32'(wr_cnt),   32'(w0));
    chk("rm_hit0",    32'(hit_cnt),  32'd0);
    chk("rm_miss0",   32'(miss_cnt), 32'd0);
    chk("rm_ptr0",    32'(cam_w_addr), 32'd0);

    // Saturation: five hits against the 2-bit twin
    for (int i = 0; i < 5; i++) do_req(8'h5A, 0);
    chk("sat_main_hit", 32'(hit_cnt),   32'd5);
    chk("sat_hit3",     32'(s_hit_cnt), 32'd3);
    chk("sat_miss0",    32'(s_miss_cnt), 32'd0);

    // Wrap: nine distinct misses fill slots 0..7 then 0 again
    for (int i = 0; i < 9; i++) begin
      do_req(8'h20 + 8'(i), 0);
      chk("wrap_waddr", 32'(w_addr), 32'(i % 8));
      chk("wrap_wtag",  32'(w_tag),  32'(8'h20 + 8'(i)));
      chk("wrap_flag",  32'(rsp_h),  32'd0);
    end
    do_req(8'h20, 0);
    chk("evict_miss",  32'(rsp_h),  32'd0);
    chk("evict_waddr", 32'(w_addr), 32'd1);
    chk("evict_cnt",   32'(miss_cnt), 32'd10);
    chk("evict_sat",   32'(s_miss_cnt), 32'd3);

    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end

endmodule
`default_nettype wire
